// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
// FSM state encoding, address-region encoding and the fixed read-data
// values returned for timed-out and unmapped accesses.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_RD   = 2'd1,
      PER_WAIT = 2'd2,
      DONE     = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RGN_RAM      = 2'd0,
      RGN_PER      = 2'd1,
      RGN_UNMAPPED = 2'd2
   } region_t;

   localparam logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF;
   localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder for the bus bridge.
// Ports:
//   addr    in  cpu_addr[31:8] (lower bits never affect the region)
//   region  out RGN_RAM for the 4 KiB RAM window, RGN_PER for the
//               256-byte peripheral window, RGN_UNMAPPED otherwise
module mem_addr_decode
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE = 32'h0000_0000,
   parameter logic [31:0] PER_BASE = 32'h8000_0000
) (
   input  logic [31:8] addr,
   output region_t     region
);

   always_comb begin
      region = RGN_UNMAPPED;
      if (addr[31:12] == RAM_BASE[31:12]) begin
         region = RGN_RAM;
      end else if (addr[31:8] == PER_BASE[31:8]) begin
         region = RGN_PER;
      end
   end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges a single-master CPU memory port onto a synchronous data RAM and
// a handshaked AES peripheral, stalling the core while an access is open.
// Ports:
//   clk, reset                     clock, async active-high reset
//   cpu_req/wr_ena/addr/w_data     core request
//   cpu_r_data, cpu_stall          core response
//   ram_we/addr/wdata, ram_rdata   data RAM (1-cycle read latency)
//   per_req/we/addr/wdata          peripheral request (registered)
//   per_rdata, per_ack             peripheral completion
//   bus_err                        sticky error, cleared only by reset
// Optional: define BRIDGE_TIMEOUT_EN to bound PER_WAIT by TIMEOUT_CYCLES.
//
// state    | meaning
// IDLE     | decode cpu_req; RAM writes and unmapped accesses finish here
// RAM_RD   | RAM read data returned to the core
// PER_WAIT | peripheral request held until per_ack (or timeout)
// DONE     | captured peripheral data returned, core released
module mem_bus_bridge
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
   parameter logic [31:0] PER_BASE       = 32'h8000_0000,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_wr_ena,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_w_data,
   output logic [31:0] cpu_r_data,
   output logic        cpu_stall,
   output logic        ram_we,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        per_req,
   output logic        per_we,
   output logic [7:0]  per_addr,
   output logic [31:0] per_wdata,
   input  logic [31:0] per_rdata,
   input  logic        per_ack,
   output logic        bus_err
);

   state_t      state;
   region_t     rgn;
   logic [31:0] rd_q;
   logic        tmo_hit;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_addr[1:0];

   mem_addr_decode #(
      .RAM_BASE (RAM_BASE),
      .PER_BASE (PER_BASE)
   ) u_decode (
      .addr   (cpu_addr[31:8]),
      .region (rgn)
   );

   assign ram_addr  = cpu_addr[11:2];
   assign ram_wdata = cpu_w_data;

   // Request-cycle outputs are combinational so RAM writes and unmapped
   // accesses complete with zero wait states; reset gates them so no
   // write can slip out while reset is asserted.
   always_comb begin
      cpu_stall  = 1'b0;
      ram_we     = 1'b0;
      cpu_r_data = UNMAPPED_RDATA;
      case (state)
         IDLE: begin
            if (cpu_req && !reset) begin
               case (rgn)
                  RGN_RAM: begin
                     ram_we    = cpu_wr_ena;
                     cpu_stall = !cpu_wr_ena;
                  end
                  RGN_PER:  cpu_stall = 1'b1;
                  default:  cpu_stall = 1'b0;
               endcase
            end
         end
         RAM_RD:   cpu_r_data = ram_rdata;
         PER_WAIT: cpu_stall  = 1'b1;
         DONE:     cpu_r_data = rd_q;
         default:  cpu_stall  = 1'b0;
      endcase
   end

`ifdef BRIDGE_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Counts completed PER_WAIT cycles; the hit fires on the cycle that
   // would bring the count to TIMEOUT_CYCLES.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= 8'd0;
      end else if (state == IDLE && cpu_req && rgn == RGN_PER) begin
         tmo_cnt <= 8'd0;
      end else if (state == PER_WAIT) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   assign tmo_hit = (state == PER_WAIT) && !per_ack &&
                    ((tmo_cnt + 8'd1) == TIMEOUT_CYCLES);
`else
   localparam logic [7:0] unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         per_req   <= 1'b0;
         per_we    <= 1'b0;
         per_addr  <= 8'd0;
         per_wdata <= 32'd0;
         rd_q      <= 32'd0;
         bus_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  case (rgn)
                     RGN_RAM: begin
                        if (!cpu_wr_ena) state <= RAM_RD;
                     end
                     RGN_PER: begin
                        state     <= PER_WAIT;
                        per_req   <= 1'b1;
                        per_we    <= cpu_wr_ena;
                        per_addr  <= {cpu_addr[7:2], 2'b00};
                        per_wdata <= cpu_w_data;
                     end
                     default: bus_err <= 1'b1;
                  endcase
               end
            end
            RAM_RD: state <= IDLE;
            PER_WAIT: begin
               if (per_ack) begin
                  rd_q    <= per_rdata;
                  per_req <= 1'b0;
                  per_we  <= 1'b0;
                  state   <= DONE;
               end else if (tmo_hit) begin
                  rd_q    <= TIMEOUT_RDATA;
                  bus_err <= 1'b1;
                  per_req <= 1'b0;
                  per_we  <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_wr_ena;
   logic [31:0] cpu_addr, cpu_w_data, cpu_r_data;
   logic        cpu_stall;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        per_req, per_we;
   logic [7:0]  per_addr;
   logic [31:0] per_wdata, per_rdata;
   logic        per_ack;
   logic        bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_bus_bridge dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr_ena(cpu_wr_ena), .cpu_addr(cpu_addr),
      .cpu_w_data(cpu_w_data), .cpu_r_data(cpu_r_data), .cpu_stall(cpu_stall),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
      .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ack(per_ack),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- external RAM and peripheral models ----------------
   logic [31:0] ram_mem [1024];
   logic [31:0] per_mem [64];

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   int          ack_delay;     // 0 = peripheral never answers
   logic        late_ack;
   logic [7:0]  exp_per_addr;
   logic        exp_per_we;
   logic [31:0] exp_per_wdata;

   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      per_ack   = 1'b0;
      per_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         per_ack = 1'b0;
         if (late_ack) begin
            per_ack   = 1'b1;
            per_rdata = 32'hDEAD_BEEF;
            late_ack  = 1'b0;
         end else if (per_req && ack_delay != 0) begin
            wait_cnt++;
            if (wait_cnt == ack_delay) begin
               check("per_addr", {24'd0, per_addr}, {24'd0, exp_per_addr});
               check("per_we", {31'd0, per_we}, {31'd0, exp_per_we});
               if (exp_per_we) check("per_wdata", per_wdata, exp_per_wdata);
               per_ack   = 1'b1;
               per_rdata = per_mem[per_addr[7:2]];
               if (per_we) per_mem[per_addr[7:2]] = per_wdata;
               wait_cnt = 0;
            end
         end else if (!per_req) begin
            wait_cnt = 0;
         end
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [31:0] ref_ram [1024];
   logic [31:0] ref_per [64];
   logic [31:0] exp_q [$];
   logic        err_exp;
   logic        first_ram_we;
   logic [9:0]  first_ram_addr;

   always @(negedge clk) begin
      if (!reset && cpu_req && !cpu_wr_ena && !cpu_stall) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected actual=%h required=none", cpu_r_data);
         end else begin
            check("rd_data", cpu_r_data, exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the completing edge.
   task automatic do_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int delay);
      int  stalls, exp_stalls;
      bit  first, done;
      if (addr[31:12] == 20'h00000) begin
         exp_stalls = wr ? 0 : 1;
         if (wr) ref_ram[addr[11:2]] = data;
         else    exp_q.push_back(ref_ram[addr[11:2]]);
      end else if (addr[31:8] == 24'h800000) begin
         exp_stalls    = (delay == 0) ? 256 : delay + 1;
         exp_per_addr  = {addr[7:2], 2'b00};
         exp_per_we    = wr;
         exp_per_wdata = data;
         if (delay == 0) begin
            err_exp = 1'b1;
            if (!wr) exp_q.push_back(32'hFFFF_FFFF);
         end else if (wr) begin
            ref_per[addr[7:2]] = data;
         end else begin
            exp_q.push_back(ref_per[addr[7:2]]);
         end
      end else begin
         exp_stalls = 0;
         err_exp    = 1'b1;
         if (!wr) exp_q.push_back(32'h0);
      end
      ack_delay  = delay;
      cpu_req    = 1'b1;
      cpu_wr_ena = wr;
      cpu_addr   = addr;
      cpu_w_data = data;
      stalls = 0;
      first  = 1'b1;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (first) begin
            first_ram_we   = ram_we;
            first_ram_addr = ram_addr;
            first          = 1'b0;
         end
         if (!cpu_stall) begin
            done = 1'b1;
         end else begin
            stalls++;
            if (stalls > 400) begin
               n_tests++;
               n_fail++;
               $display("FAIL stall_timeout actual=%0d required=%0d", stalls, exp_stalls);
               done = 1'b1;
            end
         end
      end
      check("stall_cycles", stalls, exp_stalls);
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [9:0]  w;
      int          kind;
      logic        wr;
      for (int i = 0; i < 1024; i++) begin ram_mem[i] = 32'd0; ref_ram[i] = 32'd0; end
      for (int i = 0; i < 64; i++) begin per_mem[i] = 32'd0; ref_per[i] = 32'd0; end
      err_exp    = 1'b0;
      late_ack   = 1'b0;
      ack_delay  = 1;
      reset      = 1'b1;
      cpu_req    = 1'b0;
      cpu_wr_ena = 1'b0;
      cpu_addr   = 32'd0;
      cpu_w_data = 32'd0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_per_req", {31'd0, per_req}, 32'd0);
      check("rst_per_we", {31'd0, per_we}, 32'd0);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check("rst_per_addr", {24'd0, per_addr}, 32'd0);
      check("rst_per_wdata", per_wdata, 32'd0);
      check("rst_rdata", cpu_r_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // RAM write then readback
      do_txn(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 1);
      check("ramwr_we", {31'd0, first_ram_we}, 32'd1);
      check("ramwr_addr", {22'd0, first_ram_addr}, 32'd4);
      do_txn(1'b0, 32'h0000_0010, 32'h0, 1);

      // peripheral read, ack in the third wait cycle
      per_mem[1] = 32'h1234_5678;
      ref_per[1] = 32'h1234_5678;
      do_txn(1'b0, 32'h8000_0004, 32'h0, 3);
      check("per_req_drop", {31'd0, per_req}, 32'd0);

      // unmapped read
      check("err_before_unm", {31'd0, bus_err}, 32'd0);
      do_txn(1'b0, 32'h4000_0000, 32'h0, 1);
      check("err_after_unm", {31'd0, bus_err}, 32'd1);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 19);
         wr   = 1'($urandom);
         if (kind < 10) begin
            w = 10'($urandom_range(0, 15) * 67);
            a = {20'h00000, w, 2'($urandom)};
         end else if (kind < 17) begin
            a = {24'h800000, 6'($urandom_range(0, 63)), 2'($urandom)};
         end else begin
            a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
         end
         do_txn(wr, a, $urandom, $urandom_range(1, 5));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            check("idle_stall", {31'd0, cpu_stall}, 32'd0);
            @(posedge clk); #1;
         end
      end
      check("err_sticky", {31'd0, bus_err}, {31'd0, err_exp});

      // reset while the peripheral is being waited on
      ack_delay  = 0;
      cpu_req    = 1'b1;
      cpu_wr_ena = 1'b1;
      cpu_addr   = 32'h8000_0008;
      cpu_w_data = 32'h5555_AAAA;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rstw_per_req", {31'd0, per_req}, 32'd0);
      check("rstw_stall", {31'd0, cpu_stall}, 32'd0);
      check("rstw_ram_we", {31'd0, ram_we}, 32'd0);
      exp_q.delete();
      err_exp = 1'b0;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      reset    = 1'b0;
      late_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("late_ack_req", {31'd0, per_req}, 32'd0);
      check("late_ack_stall", {31'd0, cpu_stall}, 32'd0);
      check("late_ack_err", {31'd0, bus_err}, 32'd0);
      do_txn(1'b1, 32'h0000_0ABC, 32'hC0FF_EE00, 1);
      check("post_rst_we", {31'd0, first_ram_we}, 32'd1);
      do_txn(1'b0, 32'h0000_0ABC, 32'h0, 1);

`ifdef BRIDGE_TIMEOUT_EN
      do_txn(1'b0, 32'h8000_0010, 32'h0, 0);
      check("tmo_err", {31'd0, bus_err}, 32'd1);
      check("tmo_per_req", {31'd0, per_req}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'h0000_0000: base of the 4 KiB data-RAM window.
REQ-002 SHALL have parameter PER_BASE, default 32'h8000_0000: base of the 256-byte AES peripheral window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 8'd255: peripheral wait limit, used only when the timeout feature is compiled in.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  memory transaction valid, from the core's request output.
- cpu_wr_ena  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_w_data  in  32  write data.
- cpu_r_data  out  32  read data to the core.
- cpu_stall  out  1  holds the core.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  10  RAM word address, cpu_addr[11:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; synchronous, valid 1 cycle after the address.
- per_req  out  1  peripheral request.
- per_we  out  1  peripheral write.
- per_addr  out  8  peripheral byte offset.
- per_wdata  out  32  peripheral write data.
- per_rdata  in  32  peripheral read data, valid with per_ack.
- per_ack  in  1  one-cycle peripheral completion.
- bus_err  out  1  sticky error flag.

Function
REQ-005 SHALL decode each request in IDLE:
- RAM: cpu_addr[31:12] == RAM_BASE[31:12].
- PER: cpu_addr[31:8] == PER_BASE[31:8].
- Anything else is UNMAPPED.
REQ-006 SHALL implement FSM states IDLE, RAM_RD, PER_WAIT, DONE.
REQ-007 RAM write: ram_we=1 combinationally in the request cycle, cpu_stall=0, state stays IDLE (zero wait states).
REQ-008 RAM read:
- Request cycle: cpu_stall=1, next state RAM_RD.
- RAM_RD cycle: cpu_r_data=ram_rdata, cpu_stall=0, next state IDLE.
REQ-009 PER access:
- Request cycle: cpu_stall=1, next state PER_WAIT.
- In PER_WAIT: per_req, per_we, per_addr and per_wdata are registered and held stable until per_ack.
REQ-010 On per_ack in PER_WAIT:
- Capture per_rdata into rd_q and go to DONE.
- per_req SHALL drop in the DONE cycle.
REQ-011 DONE: cpu_stall=0, cpu_r_data=rd_q (writes also pass through DONE), next state IDLE.
REQ-012 The request still present on cpu_req in RAM_RD or DONE SHALL NOT be re-decoded; decoding happens only in IDLE.
REQ-013 UNMAPPED access:
- Writes are dropped; reads return 32'h0000_0000.
- cpu_stall=0, bus_err is set.
REQ-014 per_ack outside PER_WAIT SHALL be ignored.
REQ-015 cpu_stall SHALL be 0 in IDLE whenever cpu_req=0.

Reset
REQ-016 Reset SHALL force:
- state=IDLE.
- cpu_stall=0, per_req=0, per_we=0, ram_we=0, bus_err=0.
- rd_q=0, per_addr=0, per_wdata=0, timeout counter=0.
REQ-017 Reset asserted mid-transaction SHALL abort immediately. No write completes after reset asserts.
REQ-018 bus_err SHALL clear only on reset.

Configuration
REQ-019 Macro BRIDGE_TIMEOUT_EN defined:
- An 8-bit counter increments each PER_WAIT cycle and clears on entry to PER_WAIT.
- When it reaches TIMEOUT_CYCLES without per_ack: go to DONE, rd_q=32'hFFFF_FFFF, set bus_err, drop per_req.
REQ-020 BRIDGE_TIMEOUT_EN undefined: no counter exists, and PER_WAIT waits indefinitely for per_ack.

Structure
REQ-021 Package mem_bus_pkg SHALL hold:
- The state enum.
- Region enum {RGN_RAM, RGN_PER, RGN_UNMAPPED}.
- Constants TIMEOUT_RDATA=32'hFFFF_FFFF and UNMAPPED_RDATA=32'h0.
REQ-022 Sub-module mem_addr_decode SHALL map cpu_addr to a region as pure combinational logic.

Verification
REQ-023 RAM write:
- Stimulus: write 0x0000_0010 data 0xA5A5_A5A5.
- Response: ram_we=1 with ram_addr=4 in the same cycle, cpu_stall=0.
- Readback of the same address: stall for 1 cycle, cpu_r_data=0xA5A5_A5A5.
REQ-024 Peripheral read:
- Stimulus: read 0x8000_0004, per_ack after 3 cycles with per_rdata=0x1234_5678.
- Response: per_addr=0x04 held; stall high 4 cycles, low in DONE; cpu_r_data=0x1234_5678.
REQ-025 Unmapped read:
- Stimulus: read 0x4000_0000.
- Response: cpu_r_data=0, no stall, bus_err=1 and stays 1.
REQ-026 Timeout (BRIDGE_TIMEOUT_EN defined):
- Stimulus: peripheral read, per_ack never asserted.
- Response: DONE after 255 wait cycles, cpu_r_data=0xFFFF_FFFF, bus_err=1.
REQ-027 Reset mid-wait:
- Stimulus: assert reset during PER_WAIT.
- Response: per_req=0 and cpu_stall=0 asynchronously.
- A late per_ack after reset releases is ignored and state stays IDLE.
